// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the execute-stage M-extension unit.
package riscv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Signed divide/remainder: DIV and REM (funct3[2]=1, funct3[0]=0).
  function automatic logic is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// EX-stage <-> multiply/divide unit signals.
// Handshake: an op issues in an IDLE cycle with start=1 and flush=0; busy is high from
// that cycle until the done pulse, and start must be held while busy (ID/EX is stalled).
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, op_a, op_b, flush, input busy, done, result);
  modport slave  (input start, funct3, op_a, op_b, flush, output busy, done, result);
endinterface

// File: rtl/serial_divider.sv
// Unsigned restoring divider, one quotient bit per cycle after load.
// quotient/remainder show the values after the step taken in the current cycle.
module serial_divider #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            Rst,
  input  logic            load,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder,
  output logic            last
);
  localparam int CW = $clog2(XLEN);

  logic [XLEN-1:0] rem_q, dvd_q, dsr_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN:0]   shifted, diff;

  always_comb begin
    shifted   = {rem_q, dvd_q[XLEN-1]};
    diff      = shifted - {1'b0, dsr_q};
    // Negative difference (borrow) restores the shifted partial remainder.
    remainder = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    quotient  = {dvd_q[XLEN-2:0], ~diff[XLEN]};
    last      = (cnt_q == CW'(XLEN - 1));
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      rem_q <= '0;
      dvd_q <= '0;
      dsr_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      rem_q <= '0;
      dvd_q <= dividend;
      dsr_q <= divisor;
      cnt_q <= '0;
    end else begin
      rem_q <= remainder;
      dvd_q <= quotient;
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/ex_muldiv.sv
// RV32M execute-stage multiply/divide unit: two-cycle multiplier, 32-step divider,
// combinational stall request and a registered one-cycle done pulse.
module ex_muldiv
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        Rst,
  ex_muldiv_if.slave  bus,
  output logic [1:0]  dbg_state
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state, state_n;
  muldiv_op_e        op_q;
  logic [XLEN-1:0]   a_q, b_q, result_q, result_n;
  logic              first_q, done_q, issue;
  logic [XLEN-1:0]   div_a_in, div_b_in, div_q, div_r, q_fix, r_fix;
  logic              div_last, d_signed, is_rem, ovf;
  logic signed [XLEN:0]     ma, mb;
  logic signed [2*XLEN-1:0] prod;

  assign issue     = Rst && (state == S_IDLE) && bus.start && !bus.flush;
  assign bus.busy  = issue || (state == S_MUL) || (state == S_DIV);
  assign bus.done  = done_q;
  assign bus.result = result_q;
  assign dbg_state = state;

  // Divider is loaded at the issue edge so the 32 steps fill the DIV cycles exactly.
  assign div_a_in = (is_signed_div(bus.funct3) && bus.op_a[XLEN-1]) ? -bus.op_a : bus.op_a;
  assign div_b_in = (is_signed_div(bus.funct3) && bus.op_b[XLEN-1]) ? -bus.op_b : bus.op_b;

  serial_divider #(.XLEN(XLEN)) u_div (
    .clk       (clk),
    .Rst       (Rst),
    .load      (issue),
    .dividend  (div_a_in),
    .divisor   (div_b_in),
    .quotient  (div_q),
    .remainder (div_r),
    .last      (div_last)
  );

  always_comb begin
    ma   = {(op_q != OP_MULHU) & a_q[XLEN-1], a_q};
    mb   = {((op_q == OP_MUL) || (op_q == OP_MULH)) & b_q[XLEN-1], b_q};
    prod = ma * mb;
    d_signed = is_signed_div(op_q);
    is_rem   = op_q[1];
    ovf      = d_signed && (a_q == {1'b1, {(XLEN-1){1'b0}}}) && (b_q == '1);
    q_fix    = (d_signed && (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -div_q : div_q;
    r_fix    = (d_signed && a_q[XLEN-1]) ? -div_r : div_r;
  end

  always_comb begin
    state_n  = state;
    result_n = result_q;
    case (state)
      S_IDLE: if (issue) state_n = bus.funct3[2] ? S_DIV : S_MUL;
      S_MUL: begin
        if (bus.flush) state_n = S_IDLE;
        else begin
          state_n  = S_DONE;
          result_n = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        end
      end
      S_DIV: begin
        if (bus.flush) state_n = S_IDLE;
        else if (first_q && (b_q == '0)) begin
          state_n  = S_DONE;
          result_n = is_rem ? a_q : '1;
        end else if (first_q && ovf) begin
          state_n  = S_DONE;
          result_n = is_rem ? '0 : a_q;
        end else if (div_last) begin
          state_n  = S_DONE;
          result_n = is_rem ? r_fix : q_fix;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state    <= S_IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      first_q  <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state    <= state_n;
      result_q <= result_n;
      done_q   <= (state_n == S_DONE);
      first_q  <= issue;
      if (issue) begin
        op_q <= muldiv_op_e'(bus.funct3);
        a_q  <= bus.op_a;
        b_q  <= bus.op_b;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: latency, busy window, results, special cases, flush and reset.
module tb_ex_muldiv;
  logic       clk;
  logic       Rst;
  logic [1:0] dbg_state;
  int checks;
  int failures;

  ex_muldiv_if bus ();

  ex_muldiv dut (
    .clk       (clk),
    .Rst       (Rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive an op in an IDLE cycle (cycle T) and confirm the combinational stall.
  task automatic issue(input string tag, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op_a   = a;
    bus.op_b   = b;
    #1;
    check({tag, " busy_T"}, 32'(bus.busy), 32'd1);
  endtask

  // Start stays held until after the done cycle, as a stalled ID/EX would.
  task automatic finish_op(input string tag, input logic [31:0] exp, input int lat);
    int k;
    logic busy_ok;
    k = 0;
    busy_ok = 1'b1;
    while (k < 40) begin
      @(negedge clk);
      k++;
      #1;
      if (bus.done) break;
      if (!bus.busy) busy_ok = 1'b0;
    end
    check({tag, " latency"}, 32'(k), 32'(lat));
    check({tag, " busy_window"}, 32'(busy_ok), 32'd1);
    check({tag, " busy_at_done"}, 32'(bus.busy), 32'd0);
    check({tag, " result"}, bus.result, exp);
    @(negedge clk);
    bus.start = 1'b0;
    #1;
    check({tag, " single_pulse"}, 32'(bus.done), 32'd0);
    check({tag, " no_reissue"}, 32'(dbg_state), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    issue(tag, f3, a, b);
    finish_op(tag, exp, lat);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    Rst = 1'b0;
    bus.start = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset result", bus.result, 32'd0);
    check("reset state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    Rst = 1'b1;

    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 2);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 2);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 2);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);

    // Flush in IDLE must block issue.
    @(negedge clk);
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.funct3 = 3'b000;
    #1;
    check("idle_flush busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("idle_flush state", 32'(dbg_state), 32'd0);

    // Flush at T+10 of a DIV, then a MUL issued at T+11.
    issue("flush_div", 3'b101, 32'd1000, 32'd3);
    repeat (10) @(negedge clk);
    bus.flush = 1'b1;
    #1;
    check("flush busy_in_flush", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op_a   = 32'd6;
    bus.op_b   = 32'd7;
    #1;
    check("flush no_done", 32'(bus.done), 32'd0);
    check("flush result_kept", bus.result, 32'd2);
    check("flush mul busy_T", 32'(bus.busy), 32'd1);
    finish_op("flush_mul", 32'd42, 2);

    run_op("divu_by0",  3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 2);
    run_op("rem_by0",   3'b110, 32'd5,        32'd0,        32'd5,        2);
    run_op("div_ovf",   3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
    run_op("rem_ovf",   3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        2);
    run_op("mul_after", 3'b000, 32'd9,        32'd9,        32'd81,       2);

    // Reset at T+5 of a DIV with start still asserted.
    issue("rst_div", 3'b100, 32'd500, 32'd5);
    repeat (5) @(negedge clk);
    Rst = 1'b0;
    #1;
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst result", bus.result, 32'd0);
    check("rst state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    bus.start = 1'b0;
    Rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("post_rst done", 32'(bus.done), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
